// File: rtl/operand_entry_if.sv
// Button/switch inputs and operand/status outputs of the operand loader.
// The slave modport is the loader itself; the master side drives the raw inputs.
interface operand_entry_if #(
   parameter int WIDTH = 8
);
   logic             but_1;
   logic [WIDTH-1:0] sw;
   logic [WIDTH-1:0] A_wire;
   logic [WIDTH-1:0] B_wire;
   logic             go;
   logic [1:0]       state;

   modport master (
      output but_1, sw,
      input  A_wire, B_wire, go, state
   );

   modport slave (
      input  but_1, sw,
      output A_wire, B_wire, go, state
   );
endinterface

// File: rtl/operand_entry.sv
// Debounced push-button operand loader: first press captures the switches into A,
// second into B with a one-cycle go strobe, third press returns to A entry.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   LOAD_A | waiting for the press that captures the switches into A
//   LOAD_B | waiting for the press that captures into B and fires go
//   SHOW   | both operands held; the next press goes back to LOAD_A
module operand_entry #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic            clk,
   input  logic            reset,
   operand_entry_if.slave  bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      LOAD_A = 2'b00,
      LOAD_B = 2'b01,
      SHOW   = 2'b10
   } state_t;

   logic             b_s1, b_s2;
   logic [WIDTH-1:0] sw_s1, sw_s2;
   logic             stable, stable_d;
   logic [CW-1:0]    cnt;
   logic             press;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             go_q;

   // stable_d lets press fire one cycle after the debounced level falls
   always_ff @(posedge clk) begin
      if (reset) begin
         b_s1     <= 1'b1;
         b_s2     <= 1'b1;
         sw_s1    <= '0;
         sw_s2    <= '0;
         stable   <= 1'b1;
         stable_d <= 1'b1;
         cnt      <= '0;
         press    <= 1'b0;
      end else begin
         b_s1     <= bus.but_1;
         b_s2     <= b_s1;
         sw_s1    <= bus.sw;
         sw_s2    <= sw_s1;
         stable_d <= stable;
         press    <= stable_d & ~stable;
         if (b_s2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            stable <= b_s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD_A;
         a_q     <= '0;
         b_q     <= '0;
         go_q    <= 1'b0;
      end else begin
         go_q <= 1'b0;
         if (press) begin
            case (state_q)
               LOAD_A: begin
                  a_q     <= sw_s2;
                  state_q <= LOAD_B;
               end
               LOAD_B: begin
                  b_q     <= sw_s2;
                  go_q    <= 1'b1;
                  state_q <= SHOW;
               end
               default: state_q <= LOAD_A;
            endcase
         end
      end
   end

   assign bus.A_wire = a_q;
   assign bus.B_wire = b_q;
   assign bus.go     = go_q;
   assign bus.state  = state_q;
endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: a press-level model predicts every output
// change and its edge; a negedge monitor pops and compares each change the DUT shows.
module tb_operand_entry;
   localparam int N = 4;
   localparam int W = 8;

   typedef struct {
      int         cyc;
      logic [1:0] st;
      logic [7:0] a;
      logic [7:0] b;
      logic       go;
   } obs_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   operand_entry_if #(.WIDTH(W)) bus ();

   operand_entry #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   obs_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;

   // reference model state
   logic       m_level;
   int         m_run;
   int         m_fire;
   int         m_presses;
   logic [7:0] m_a, m_b;
   logic       m_go;
   logic [7:0] sw_hist[16];
   obs_t       m_prev = '{0, 2'b00, 8'h00, 8'h00, 1'b0};

   function automatic logic same(obs_t x, obs_t y);
      return (x.st == y.st) && (x.a == y.a) && (x.b == y.b) && (x.go == y.go);
   endfunction

   always @(posedge clk) begin
      obs_t cur;
      cyc = cyc + 1;
      sw_hist[cyc % 16] = bus.sw;
      if (reset) begin
         m_level   = 1'b1;
         m_run     = 0;
         m_fire    = -1;
         m_presses = 0;
         m_a       = 8'h00;
         m_b       = 8'h00;
         m_go      = 1'b0;
      end else begin
         m_go = 1'b0;
         if (m_fire == cyc) begin
            m_fire = -1;
            case (m_presses % 3)
               0: m_a = sw_hist[(cyc - 2) % 16];
               1: begin
                  m_b  = sw_hist[(cyc - 2) % 16];
                  m_go = 1'b1;
               end
               default: ;
            endcase
            m_presses = m_presses + 1;
         end
         // a level is accepted after N consecutive raw samples that disagree with it
         if (bus.but_1 != m_level) begin
            m_run = m_run + 1;
            if (m_run == N) begin
               m_level = bus.but_1;
               m_run   = 0;
               if (m_level == 1'b0) m_fire = cyc + 4;
            end
         end else begin
            m_run = 0;
         end
      end
      cur.cyc = cyc;
      cur.st  = 2'(m_presses % 3);
      cur.a   = m_a;
      cur.b   = m_b;
      cur.go  = m_go;
      if (!same(cur, m_prev)) exp_q.push_back(cur);
      m_prev = cur;
   end

   obs_t d_prev = '{0, 2'b00, 8'h00, 8'h00, 1'b0};

   always @(negedge clk) begin
      obs_t d, e;
      if (cyc >= 1) begin
         d.cyc = cyc;
         d.st  = bus.state;
         d.a   = bus.A_wire;
         d.b   = bus.B_wire;
         d.go  = bus.go;
         if (d.go) begin
            compared++;
            if (d_prev.go) begin
               mismatched++;
               $display("FAIL go_width cyc=%0d: go high two cycles in a row, required single-cycle", cyc);
            end
         end
         if (!same(d, d_prev)) begin
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_change cyc=%0d: got st=%0d A=%h B=%h go=%0b, required no change",
                        cyc, d.st, d.a, d.b, d.go);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || !same(d, e)) begin
                  mismatched++;
                  $display("FAIL output_change: got cyc=%0d st=%0d A=%h B=%h go=%0b, required cyc=%0d st=%0d A=%h B=%h go=%0b",
                           cyc, d.st, d.a, d.b, d.go, e.cyc, e.st, e.a, e.b, e.go);
               end
            end
         end
         d_prev = d;
      end
   end

   task automatic chk(string name, int act, int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic hold(logic lvl, int n);
      for (int i = 0; i < n; i++) begin
         bus.but_1 = lvl;
         @(negedge clk);
      end
   endtask

   task automatic chk_all(string tag, int st, int a, int b);
      chk({tag, "_state"}, int'(bus.state), st);
      chk({tag, "_A"}, int'(bus.A_wire), a);
      chk({tag, "_B"}, int'(bus.B_wire), b);
      chk({tag, "_go"}, int'(bus.go), 0);
   endtask

   initial begin
      reset     = 1'b1;
      bus.but_1 = 1'b0;
      bus.sw    = 8'h3C;
      repeat (3) @(negedge clk);
      chk_all("reset", 0, 8'h00, 8'h00);
      reset = 1'b0;

      // button held through reset acts as the A press
      hold(1'b0, 20);
      chk_all("load_a", 1, 8'h3C, 8'h00);
      hold(1'b1, 12);
      chk_all("release_a", 1, 8'h3C, 8'h00);

      bus.sw = 8'hC5;
      hold(1'b0, 20);
      hold(1'b1, 12);
      chk_all("load_b", 2, 8'h3C, 8'hC5);

      hold(1'b0, 3); hold(1'b1, 1); hold(1'b0, 3); hold(1'b1, 2);
      hold(1'b1, 10);
      chk_all("bounce", 2, 8'h3C, 8'hC5);
      hold(1'b0, 10);
      hold(1'b1, 12);
      chk_all("wrap", 0, 8'h3C, 8'hC5);

      bus.sw = 8'hFF;
      hold(1'b0, 10);
      hold(1'b1, 12);
      chk_all("reload_a", 1, 8'hFF, 8'hC5);

      // reset while a B press is mid-debounce
      bus.sw = 8'h5A;
      hold(1'b0, 4);
      reset = 1'b1;
      @(negedge clk);
      chk_all("mid_reset", 0, 8'h00, 8'h00);
      reset = 1'b0;
      hold(1'b0, 15);
      chk_all("after_reset", 1, 8'h5A, 8'h00);
      hold(1'b1, 12);

      for (int k = 0; k < 300; k++) begin
         int   len;
         logic lvl;
         len = int'($urandom_range(1, 12));
         lvl = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 40) == 0) reset = 1'b1;
         for (int j = 0; j < len; j++) begin
            bus.sw    = 8'($urandom);
            bus.but_1 = lvl;
            @(negedge clk);
            reset = 1'b0;
         end
      end

      hold(1'b1, 20);
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL pending_changes: got %0d unseen predicted changes, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
